// File: rtl/mpei_gptimer_nch.sv
// Multi-channel general-purpose timer.
// A shared prescaler produces a tick; each channel counts ticks (or the underflow of the
// previous channel when chained), reloads or stops on underflow, and can raise a sticky
// pending bit that feeds a level interrupt. Debug halt freezes all counting.
module mpei_gptimer_nch #(
    parameter int unsigned NCH = 4,
    parameter int unsigned TW  = 32,
    parameter int unsigned PW  = 16,
    parameter int unsigned AW  = $clog2(NCH) + 3
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            reg_we_i,
    input  logic            reg_re_i,
    input  logic [AW-1:0]   reg_addr_i,
    input  logic [31:0]     reg_wdata_i,
    output logic [31:0]     reg_rdata_o,
    input  logic            dhalt_i,
    output logic [NCH:0]    timr_tick_o,
    output logic            irq_o,
    output logic [NCH-1:0]  irq_pend_o
);

    // Register offsets within a group
    localparam logic [1:0] RegGScalerReload = 2'd0;
    localparam logic [1:0] RegGScalerValue  = 2'd1;
    localparam logic [1:0] RegGPending      = 2'd2;
    localparam logic [1:0] RegCReload       = 2'd0;
    localparam logic [1:0] RegCCounter      = 2'd1;
    localparam logic [1:0] RegCCtrl         = 2'd2;

    // CTRL bit positions
    localparam int unsigned CtrlEn      = 0;
    localparam int unsigned CtrlRestart = 1;
    localparam int unsigned CtrlLoad    = 2;
    localparam int unsigned CtrlIrqEn   = 3;
    localparam int unsigned CtrlChain   = 4;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PW-1:0]  scaler_rel_q, scaler_rel_d;
    logic [PW-1:0]  scaler_val_q, scaler_val_d;

    logic [TW-1:0]  reload_q [NCH];
    logic [TW-1:0]  reload_d [NCH];
    logic [TW-1:0]  cnt_q    [NCH];
    logic [TW-1:0]  cnt_d    [NCH];

    logic [NCH-1:0] en_q, en_d;
    logic [NCH-1:0] restart_q, restart_d;
    logic [NCH-1:0] irq_en_q, irq_en_d;
    logic [NCH-1:0] chain_q, chain_d;
    logic [NCH-1:0] pend_q, pend_d;

    logic [NCH:0]   tick_q, tick_d;
    logic           irq_q, irq_d;
    logic [31:0]    rdata_q, rdata_d;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic          sel_chan;
    logic [1:0]    sel_reg;
    logic [AW-2:0] sel_idx;
    logic          glb_we;

    assign sel_chan = reg_addr_i[AW-1];
    assign sel_reg  = reg_addr_i[1:0];
    // Channel index sits above the two register-select bits; zero-width when NCH is 1
    assign sel_idx  = reg_addr_i[AW-2:0] >> 2;
    assign glb_we   = reg_we_i && !sel_chan;

    // Upper write-data bits beyond the implemented widths are intentionally ignored
    logic unused_wdata;
    assign unused_wdata = ^reg_wdata_i;

    logic [NCH-1:0] chan_hit;
    logic [NCH-1:0] rel_we;
    logic [NCH-1:0] cnt_we;
    logic [NCH-1:0] ctl_we;
    logic [NCH-1:0] cnt_ovr;

    // Per-channel write strobes; indices >= NCH match nothing and are dropped
    always_comb begin
        chan_hit = '0;
        rel_we   = '0;
        cnt_we   = '0;
        ctl_we   = '0;
        cnt_ovr  = '0;
        for (int c = 0; c < NCH; c++) begin
            chan_hit[c] = reg_we_i && sel_chan && (32'(sel_idx) == 32'(c));
            rel_we[c]   = chan_hit[c] && (sel_reg == RegCReload);
            cnt_we[c]   = chan_hit[c] && (sel_reg == RegCCounter);
            ctl_we[c]   = chan_hit[c] && (sel_reg == RegCCtrl);
            // A direct counter load outranks any decrement in the same cycle
            cnt_ovr[c]  = cnt_we[c] || (ctl_we[c] && reg_wdata_i[CtrlLoad]);
        end
    end

    // ------------------------------------------------------------------
    // Prescaler
    // ------------------------------------------------------------------
    logic presc_tick;

    assign presc_tick = !dhalt_i && (scaler_val_q == '0);

    // Prescaler reload register and down-counter next state
    always_comb begin
        scaler_rel_d = scaler_rel_q;
        if (glb_we && (sel_reg == RegGScalerReload)) begin
            scaler_rel_d = reg_wdata_i[PW-1:0];
        end
        scaler_val_d = scaler_val_q;
        if (!dhalt_i) begin
            scaler_val_d = presc_tick ? scaler_rel_q : scaler_val_q - PW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Channels
    // ------------------------------------------------------------------
    logic [NCH-1:0] ch_evt;
    logic [NCH-1:0] ch_uf;
    logic           ripple;

    // Decrement events and underflows; chained channels ripple within the cycle
    always_comb begin
        ch_evt = '0;
        ch_uf  = '0;
        ripple = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            ch_evt[c] = (c != 0 && chain_q[c]) ? ripple : presc_tick;
            ch_uf[c]  = ch_evt[c] && en_q[c] && (cnt_q[c] == '0) && !cnt_ovr[c];
            ripple    = ch_uf[c];
        end
    end

    // Channel register next state
    always_comb begin
        reload_d  = reload_q;
        cnt_d     = cnt_q;
        en_d      = en_q;
        restart_d = restart_q;
        irq_en_d  = irq_en_q;
        chain_d   = chain_q;
        for (int c = 0; c < NCH; c++) begin
            if (rel_we[c]) begin
                reload_d[c] = reg_wdata_i[TW-1:0];
            end

            if (cnt_we[c]) begin
                cnt_d[c] = reg_wdata_i[TW-1:0];
            end else if (ctl_we[c] && reg_wdata_i[CtrlLoad]) begin
                cnt_d[c] = reload_q[c];
            end else if (ch_evt[c] && en_q[c]) begin
                if (cnt_q[c] != '0) begin
                    cnt_d[c] = cnt_q[c] - TW'(1);
                end else if (restart_q[c]) begin
                    cnt_d[c] = reload_q[c];
                end
                // One-shot underflow leaves the counter parked at zero
            end

            if (ctl_we[c]) begin
                // Software's EN value beats the one-shot auto-clear
                en_d[c]      = reg_wdata_i[CtrlEn];
                restart_d[c] = reg_wdata_i[CtrlRestart];
                irq_en_d[c]  = reg_wdata_i[CtrlIrqEn];
                chain_d[c]   = reg_wdata_i[CtrlChain];
            end else if (ch_uf[c] && !restart_q[c]) begin
                en_d[c] = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pending, interrupt and tick outputs
    // ------------------------------------------------------------------
    logic [NCH-1:0] pend_clr;
    logic [NCH-1:0] pend_set;

    // Sticky pending bits; a new set beats a write-1-clear
    always_comb begin
        pend_clr = '0;
        if (glb_we && (sel_reg == RegGPending)) begin
            pend_clr = reg_wdata_i[NCH-1:0];
        end
        pend_set = ch_uf & irq_en_q;
        pend_d   = (pend_q & ~pend_clr) | pend_set;
        irq_d    = |pend_d;
        tick_d   = {ch_uf, presc_tick};
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic [31:0] rd_val;

    // Read mux; unimplemented bits and absent channels read zero
    always_comb begin
        rd_val = '0;
        if (!sel_chan) begin
            unique case (sel_reg)
                RegGScalerReload: rd_val[PW-1:0]  = scaler_rel_q;
                RegGScalerValue:  rd_val[PW-1:0]  = scaler_val_q;
                RegGPending:      rd_val[NCH-1:0] = pend_q;
                default:          rd_val          = '0;
            endcase
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (32'(sel_idx) == 32'(c)) begin
                    unique case (sel_reg)
                        RegCReload:  rd_val[TW-1:0] = reload_q[c];
                        RegCCounter: rd_val[TW-1:0] = cnt_q[c];
                        RegCCtrl:    rd_val[4:0]    = {chain_q[c], irq_en_q[c], 1'b0,
                                                       restart_q[c], en_q[c]};
                        default:     rd_val         = '0;
                    endcase
                end
            end
        end
        rdata_d = reg_re_i ? rd_val : rdata_q;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------

    // Prescaler state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scaler_rel_q <= '1;
            scaler_val_q <= '0;
        end else begin
            scaler_rel_q <= scaler_rel_d;
            scaler_val_q <= scaler_val_d;
        end
    end

    // Channel state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            reload_q  <= '{default: '0};
            cnt_q     <= '{default: '0};
            en_q      <= '0;
            restart_q <= '0;
            irq_en_q  <= '0;
            chain_q   <= '0;
        end else begin
            reload_q  <= reload_d;
            cnt_q     <= cnt_d;
            en_q      <= en_d;
            restart_q <= restart_d;
            irq_en_q  <= irq_en_d;
            chain_q   <= chain_d;
        end
    end

    // Pending bits, registered outputs and read data
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_q  <= '0;
            irq_q   <= 1'b0;
            tick_q  <= '0;
            rdata_q <= '0;
        end else begin
            pend_q  <= pend_d;
            irq_q   <= irq_d;
            tick_q  <= tick_d;
            rdata_q <= rdata_d;
        end
    end

    assign reg_rdata_o = rdata_q;
    assign timr_tick_o = tick_q;
    assign irq_o       = irq_q;
    assign irq_pend_o  = pend_q;

endmodule

// File: tb/tb_mpei_gptimer_nch.sv
// Self-checking bench for mpei_gptimer_nch: directed scenarios followed by random traffic,
// all compared cycle by cycle against a behavioural model of the timer.
module tb_mpei_gptimer_nch;

    localparam int NCH = 4;
    localparam int TW  = 32;
    localparam int PW  = 16;
    localparam int AW  = $clog2(NCH) + 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            we;
    logic            re;
    logic [AW-1:0]   addr;
    logic [31:0]     wd;
    logic            dh;
    logic [31:0]     rdata;
    logic [NCH:0]    tick;
    logic            irq;
    logic [NCH-1:0]  pend;

    always #5 clk = ~clk;

    mpei_gptimer_nch #(
        .NCH (NCH),
        .TW  (TW),
        .PW  (PW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .reg_we_i    (we),
        .reg_re_i    (re),
        .reg_addr_i  (addr),
        .reg_wdata_i (wd),
        .reg_rdata_o (rdata),
        .dhalt_i     (dh),
        .timr_tick_o (tick),
        .irq_o       (irq),
        .irq_pend_o  (pend)
    );

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    bit hold    = 1'b0;

    // ---------------- behavioural model ----------------
    logic [15:0]    m_srel;
    logic [15:0]    m_sval;
    logic [31:0]    m_rel  [NCH];
    logic [31:0]    m_cnt  [NCH];
    bit   [NCH-1:0] m_en, m_rs, m_ie, m_chn, m_pend;
    bit   [NCH:0]   m_tick;
    bit             m_irq;
    logic [31:0]    m_rdata;

    task automatic model_step(input bit r, input bit w, input bit rd, input logic [AW-1:0] a,
                              input logic [31:0] d, input bit h);
        bit           tk;
        bit           ev;
        bit           carry;
        bit [NCH-1:0] uf;
        bit [NCH-1:0] setp;
        bit           gl;
        int           ci;
        int           rg;
        if (r) begin
            m_srel = 16'hFFFF; m_sval = '0;
            for (int c = 0; c < NCH; c++) begin m_rel[c] = '0; m_cnt[c] = '0; end
            m_en = '0; m_rs = '0; m_ie = '0; m_chn = '0; m_pend = '0;
            m_tick = '0; m_irq = 0; m_rdata = '0;
            return;
        end
        gl = !a[AW-1];
        ci = int'(a[AW-2:2]);
        rg = int'(a[1:0]);
        if (rd) begin
            m_rdata = '0;
            if (gl) begin
                if (rg == 0) m_rdata = {16'h0, m_srel};
                if (rg == 1) m_rdata = {16'h0, m_sval};
                if (rg == 2) m_rdata = 32'(m_pend);
            end else if (ci < NCH) begin
                if (rg == 0) m_rdata = m_rel[ci];
                if (rg == 1) m_rdata = m_cnt[ci];
                if (rg == 2) m_rdata = {27'h0, m_chn[ci], m_ie[ci], 1'b0, m_rs[ci], m_en[ci]};
            end
        end
        tk    = !h && (m_sval == 0);
        carry = 0;
        uf    = '0;
        setp  = '0;
        for (int c = 0; c < NCH; c++) begin
            bit wr_here;
            wr_here = w && !gl && (ci == c);
            ev = (c > 0 && m_chn[c]) ? carry : tk;
            if (wr_here && rg == 1) m_cnt[c] = d;
            else if (wr_here && rg == 2 && d[2]) m_cnt[c] = m_rel[c];
            else if (ev && m_en[c]) begin
                if (m_cnt[c] > 0) m_cnt[c] = m_cnt[c] - 1;
                else begin
                    uf[c] = 1;
                    m_cnt[c] = m_rs[c] ? m_rel[c] : 32'h0;
                end
            end
            carry   = uf[c];
            setp[c] = uf[c] && m_ie[c];
            if (wr_here && rg == 2) begin
                m_en[c] = d[0]; m_rs[c] = d[1]; m_ie[c] = d[3]; m_chn[c] = d[4];
            end else if (uf[c] && !m_rs[c]) begin
                m_en[c] = 0;
            end
            if (wr_here && rg == 0) m_rel[c] = d;
        end
        if (!h) m_sval = (m_sval == 0) ? m_srel : m_sval - 1;
        if (w && gl && rg == 0) m_srel = d[15:0];
        if (w && gl && rg == 2) m_pend = m_pend & ~d[NCH-1:0];
        m_pend = m_pend | setp;
        m_irq  = |m_pend;
        m_tick = {uf, tk};
    endtask

    // ---------------- checking and stimulus helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input bit r, input bit w, input bit rd, input logic [AW-1:0] a,
                       input logic [31:0] d, input bit h);
        rst = r; we = w; re = rd; addr = a; wd = d; dh = h;
        model_step(r, w, rd, a, d, h);
        @(posedge clk);
        #1;
        chk("tick", 32'(tick), 32'(m_tick));
        chk("pend", 32'(pend), 32'(m_pend));
        chk("irq", 32'(irq), 32'(m_irq));
        chk("rdata", rdata, m_rdata);
        rst = 0; we = 0; re = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, '0, '0, hold);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
        cyc(0, 1, 0, a, d, hold);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        cyc(0, 0, 1, a, '0, hold);
    endtask

    function automatic logic [AW-1:0] ga(input int r);
        return AW'(r);
    endfunction

    function automatic logic [AW-1:0] ca(input int c, input int r);
        return AW'((1 << (AW - 1)) + c * 4 + r);
    endfunction

    // ---------------- directed sequence then random traffic ----------------
    initial begin
        int            n0, n1, n2, nco, last, pos;
        logic [15:0]   sv;
        bit            r_next_fix;
        bit            r, w, rdv, h;
        logic [AW-1:0] a;
        logic [31:0]   d;

        rst = 1; we = 0; re = 0; addr = '0; wd = '0; dh = 0;

        // Reset and read back every register while frozen
        hold = 1;
        cyc(1, 0, 0, '0, '0, 1);
        cyc(1, 0, 0, '0, '0, 1);
        chk("rst_tick", 32'(tick), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        rd(ga(0)); chk("rst_scaler_reload", rdata, 32'h0000_FFFF);
        rd(ga(1)); chk("rst_scaler_value", rdata, 32'h0);
        rd(ga(2)); chk("rst_pending", rdata, 32'h0);
        rd(ga(3)); chk("rst_reserved", rdata, 32'h0);
        for (int c = 0; c < NCH; c++) begin
            for (int k = 0; k < 4; k++) begin
                rd(ca(c, k)); chk("rst_chan_reg", rdata, 32'h0);
            end
        end

        // Periodic ch0 off a /4 prescaler; scaler write truncates to PW
        wr(ga(0), 32'hABCD_0003);
        rd(ga(0)); chk("scaler_trunc", rdata, 32'h3);
        wr(ca(0, 0), 32'd2);
        wr(ca(0, 2), 32'h07);
        hold = 0;
        n0 = 0; n1 = 0; last = -1;
        for (int i = 0; i < 48; i++) begin
            idle(1);
            if (tick[0]) n0++;
            if (tick[1]) begin
                n1++;
                if (last >= 0) chk("ch0_period", 32'(i - last), 32'd12);
                last = i;
            end
        end
        chk("presc_ticks_48", 32'(n0), 32'd12);
        chk("ch0_uf_48", 32'(n1), 32'd4);

        // One-shot ch0 with interrupt
        wr(ca(0, 2), 32'h0);
        wr(ga(0), 32'h0);
        idle(5);
        wr(ca(0, 0), 32'd1);
        wr(ca(0, 2), 32'h0D);
        n1 = 0; pos = -1;
        for (int i = 0; i < 6; i++) begin
            idle(1);
            if (tick[1]) begin n1++; pos = i; end
        end
        chk("oneshot_count", 32'(n1), 32'd1);
        chk("oneshot_pos", 32'(pos), 32'd1);
        chk("oneshot_pend", 32'(pend), 32'h1);
        chk("oneshot_irq", 32'(irq), 32'h1);
        rd(ca(0, 2)); chk("oneshot_ctrl", rdata, 32'h08);
        wr(ga(2), 32'h1);
        chk("pend_clr_irq", 32'(irq), 32'h0);
        chk("pend_clr_pend", 32'(pend), 32'h0);

        // ch1 chained onto ch0
        wr(ca(0, 0), 32'd1);
        wr(ca(1, 0), 32'd2);
        wr(ca(1, 2), 32'h17);
        wr(ca(0, 2), 32'h07);
        n0 = 0; n1 = 0; n2 = 0; nco = 0;
        for (int i = 0; i < 36; i++) begin
            idle(1);
            if (tick[0]) n0++;
            if (tick[1]) n1++;
            if (tick[2]) n2++;
            if (tick[2] && tick[1]) nco++;
        end
        chk("chain_presc", 32'(n0), 32'd36);
        chk("chain_ch0", 32'(n1), 32'd18);
        chk("chain_ch1", 32'(n2), 32'd6);
        chk("chain_coincident", 32'(nco), 32'd6);

        // Debug halt freezes counter and prescaler
        wr(ca(1, 2), 32'h0);
        wr(ga(0), 32'd3);
        wr(ca(0, 0), 32'd7);
        wr(ca(0, 2), 32'h03);
        wr(ca(0, 1), 32'd5);
        sv = m_sval;
        hold = 1;
        n0 = 0;
        rd(ca(0, 1)); chk("halt_cnt_start", rdata, 32'd5);
        rd(ga(1));    chk("halt_sval_start", rdata, 32'(sv));
        for (int i = 0; i < 6; i++) begin
            idle(1);
            if (tick != '0) n0++;
        end
        rd(ca(0, 1)); chk("halt_cnt_end", rdata, 32'd5);
        rd(ga(1));    chk("halt_sval_end", rdata, 32'(sv));
        chk("halt_no_ticks", 32'(n0), 32'd0);
        hold = 0;
        idle(9);
        rd(ca(0, 1));

        // Counter write beats an underflow
        wr(ga(0), 32'h0);
        idle(5);
        wr(ca(0, 0), 32'd3);
        wr(ca(0, 2), 32'h0B);
        wr(ca(0, 1), 32'h0);
        wr(ca(0, 1), 32'h10);
        chk("ovr_no_pulse", 32'(tick[1]), 32'h0);
        chk("ovr_no_pend", 32'(pend), 32'h0);
        rd(ca(0, 1)); chk("ovr_cnt", rdata, 32'h10);

        // Pending set beats a simultaneous clear
        wr(ca(0, 0), 32'h0);
        wr(ca(0, 1), 32'h0);
        idle(2);
        chk("pend_set", 32'(pend[0]), 32'h1);
        wr(ga(2), 32'h1);
        chk("pend_set_wins", 32'(pend[0]), 32'h1);
        chk("pend_set_irq", 32'(irq), 32'h1);

        // Reset mid-count with a concurrent write
        cyc(1, 1, 0, ca(0, 2), 32'h07, 0);
        chk("midrst_tick", 32'(tick), 32'h0);
        chk("midrst_irq", 32'(irq), 32'h0);
        chk("midrst_pend", 32'(pend), 32'h0);
        chk("midrst_rdata", rdata, 32'h0);
        hold = 1;
        rd(ga(0));    chk("midrst_srel", rdata, 32'h0000_FFFF);
        rd(ca(0, 2)); chk("midrst_ctrl", rdata, 32'h0);
        rd(ca(0, 1)); chk("midrst_cnt", rdata, 32'h0);
        wr(ga(0), 32'd1);
        hold = 0;

        // Random traffic against the model
        r_next_fix = 0;
        for (int i = 0; i < 800; i++) begin
            r   = ($urandom_range(0, 299) == 0);
            w   = ($urandom_range(0, 2) == 0);
            rdv = ($urandom_range(0, 1) == 1);
            h   = ($urandom_range(0, 9) == 0);
            a   = AW'($urandom);
            d   = $urandom;
            if (!a[AW-1] && a[1:0] == 2'd0) d = ($urandom & 32'hFFFF_0000) | $urandom_range(0, 3);
            if (a[AW-1] && a[1:0] != 2'd2 && $urandom_range(0, 7) != 0) d = $urandom_range(0, 6);
            if (r_next_fix) begin
                // Load a short scaler reload while frozen so the prescaler stays lively
                r = 0; w = 1; h = 1; a = ga(0); d = $urandom_range(0, 3);
            end
            r_next_fix = r;
            cyc(r, w, rdv, a, d, h);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
